// File: rtl/timer_pkg.sv
// Shared state and mode encodings for the timer sequencer.
// Pure declarations; no logic.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  function automatic logic state_is_busy(input state_e s);
    return (s == RUN) || (s == PAUSE);
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Counter datapath: WIDTH-bit register with synchronous clear (priority) and count enable.
// Output is the register itself, so it updates one cycle after clr/en.
module timer_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/timer_sequencer.sv
// Sequences the counter: start/stop/pause, prescaled stepping, one-shot/periodic terminal tick.
// All outputs registered; priority stop > start > pause.
module timer_sequencer
  import timer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 pause,
  input  logic                 mode,
  input  logic [PRE_WIDTH-1:0] prescale,
  input  logic [WIDTH-1:0]     limit,
  output logic [WIDTH-1:0]     count,
  output logic                 tick,
  output logic                 busy,
  output logic                 done
);

  state_e               state_d, state_q;
  logic [PRE_WIDTH-1:0] presc_d, presc_q;
  logic                 mode_d, mode_q;
  logic [PRE_WIDTH-1:0] pre_d, pre_q;
  logic [WIDTH-1:0]     lim_d, lim_q;
  logic                 tick_d, tick_q;
  logic                 busy_d, busy_q;
  logic                 done_d, done_q;
  logic                 cnt_clr;
  logic                 cnt_en;
  logic                 step;
  logic                 terminal;

  assign step     = (presc_q == pre_q);
  assign terminal = (count == lim_q);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    mode_d  = mode_q;
    pre_d   = pre_q;
    lim_d   = lim_q;
    tick_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    if (stop) begin
      state_d = IDLE;
      presc_d = '0;
    end else if (start) begin
      mode_d  = mode;
      pre_d   = prescale;
      lim_d   = limit;
      presc_d = '0;
      cnt_clr = 1'b1;
      state_d = RUN;
    end else begin
      case (state_q)
        // Leaving PAUSE counts as a live RUN cycle, so a pause of N cycles delays by exactly N.
        RUN, PAUSE: begin
          if (pause) begin
            state_d = PAUSE;
          end else begin
            state_d = RUN;
            if (step) begin
              presc_d = '0;
              if (terminal) begin
                tick_d = 1'b1;
                if (mode_q == MODE_PERIODIC) begin
                  cnt_clr = 1'b1;
                end else begin
                  state_d = DONE;
                end
              end else begin
                cnt_en = 1'b1;
              end
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end

    busy_d = state_is_busy(state_d);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      mode_q  <= MODE_ONESHOT;
      pre_q   <= '0;
      lim_q   <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      mode_q  <= mode_d;
      pre_q   <= pre_d;
      lim_q   <= lim_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  timer_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .count(count)
  );

  assign tick = tick_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: vector table, directed corner sequences, random run vs. an
// arithmetic model (count = progressed cycles / (pre+1) mod (lim+1)).
module tb_timer_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       pause;
  logic       mode;
  logic [7:0] prescale;
  logic [7:0] limit;
  logic [7:0] count;
  logic       tick;
  logic       busy;
  logic       done;

  timer_sequencer #(.WIDTH(8), .PRE_WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .mode    (mode),
    .prescale(prescale),
    .limit   (limit),
    .count   (count),
    .tick    (tick),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state.
  bit     m_active;
  bit     m_done;
  bit     m_tick;
  int     m_count;
  longint m_act;
  bit     m_mode;
  int     m_pre;
  int     m_lim;

  typedef struct {
    logic       st, sp, ps, md;
    logic [7:0] pr, lm;
    int         e_cnt;
    logic       e_tick, e_busy, e_done;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic st, sp, ps, md, input logic [7:0] pr, lm,
                              input int ec, input logic et, eb, ed);
    vec_t v;
    v.st = st; v.sp = sp; v.ps = ps; v.md = md; v.pr = pr; v.lm = lm;
    v.e_cnt = ec; v.e_tick = et; v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; m_done = 0; m_tick = 0; m_count = 0; m_act = 0;
    m_mode = 0; m_pre = 0; m_lim = 0;
  endfunction

  function automatic void model_step();
    longint period;
    m_tick = 0;
    if (stop) begin
      m_active = 0;
      m_done   = 0;
    end else if (start) begin
      m_mode = mode; m_pre = int'(prescale); m_lim = int'(limit);
      m_act = 0; m_count = 0; m_active = 1; m_done = 0;
    end else if (m_active && !pause) begin
      m_act++;
      period = longint'(m_lim + 1) * longint'(m_pre + 1);
      m_tick = (m_act % period) == 0;
      if (!m_mode && m_act == period) begin
        m_active = 0;
        m_done   = 1;
        m_count  = m_lim;
      end else begin
        m_count = int'((m_act / (m_pre + 1)) % (m_lim + 1));
      end
    end
  endfunction

  task automatic check_model();
    chk("count", int'(count), m_count);
    chk("tick", int'(tick), int'(m_tick));
    chk("busy", int'(busy), int'(m_active));
    chk("done", int'(done), int'(m_done));
  endtask

  task automatic drive(input logic st, sp, ps, md, input logic [7:0] pr, lm, input bit use_model);
    @(negedge clk);
    start = st; stop = sp; pause = ps; mode = md; prescale = pr; limit = lm;
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    if (use_model) check_model();
  endtask

  task automatic idle_cycle(input logic ps, input logic [7:0] pr, lm);
    drive(1'b0, 1'b0, ps, 1'b1, pr, lm, 1'b1);
  endtask

  // Asynchronous reset between clock edges; outputs must clear without waiting for a clock.
  task automatic mid_cycle_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int start_cyc;
    int ticks;
    bit found;
    bit busy_all;

    reset = 1'b1; start = 0; stop = 0; pause = 0; mode = 0; prescale = 0; limit = 0;
    model_reset();
    #12;
    chk("reset_count", int'(count), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;

    // One-shot limit 3, pause mid-run, live-input changes, stop+start collision, limit 0 periodic.
    tbl[0]  = mk(1, 0, 0, 0, 8'd0, 8'd3,  0, 0, 1, 0);
    tbl[1]  = mk(0, 0, 0, 1, 8'd5, 8'd9,  1, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 1, 8'd5, 8'd9,  2, 0, 1, 0);
    tbl[3]  = mk(0, 0, 1, 0, 8'd0, 8'd3,  2, 0, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 8'd0, 8'd3,  3, 0, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 8'd0, 8'd3,  3, 1, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 8'd0, 8'd3,  3, 0, 0, 1);
    tbl[7]  = mk(1, 1, 0, 1, 8'd0, 8'd0,  3, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 1, 8'd0, 8'd0,  0, 0, 1, 0);
    tbl[9]  = mk(0, 0, 0, 1, 8'd0, 8'd0,  0, 1, 1, 0);
    tbl[10] = mk(0, 0, 0, 1, 8'd0, 8'd0,  0, 1, 1, 0);
    tbl[11] = mk(0, 1, 0, 1, 8'd0, 8'd0,  0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].st, tbl[i].sp, tbl[i].ps, tbl[i].md, tbl[i].pr, tbl[i].lm, 1'b0);
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].e_cnt);
      chk($sformatf("tbl%0d_tick", i), int'(tick), int'(tbl[i].e_tick));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].e_done));
    end

    // Reset mid-RUN at count 5.
    drive(1, 0, 0, 1, 8'd0, 8'd9, 1'b1);
    for (int i = 0; i < 5; i++) idle_cycle(1'b0, 8'd0, 8'd9);
    chk("pre_reset_count", int'(count), 5);
    mid_cycle_reset();

    // Periodic prescale 2, limit 1: tick every 6 cycles, busy throughout.
    drive(1, 0, 0, 1, 8'd2, 8'd1, 1'b1);
    ticks = 0; busy_all = 1;
    for (int i = 0; i < 36; i++) begin
      idle_cycle(1'b0, 8'd7, 8'd7);
      if (tick) ticks++;
      if (!busy) busy_all = 0;
    end
    chk("presc_ticks", ticks, 6);
    chk("presc_busy", int'(busy_all), 1);

    // Pause 4 cycles at count 4 with limit 9: tick moves from 10 to 14 cycles after start.
    drive(1, 0, 0, 1, 8'd0, 8'd9, 1'b1);
    start_cyc = cyc;
    for (int i = 0; i < 4; i++) idle_cycle(1'b0, 8'd0, 8'd9);
    for (int i = 0; i < 4; i++) begin
      idle_cycle(1'b1, 8'd0, 8'd9);
      chk("paused_count", int'(count), 4);
    end
    idle_cycle(1'b0, 8'd0, 8'd9);
    chk("resume_count", int'(count), 5);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      idle_cycle(1'b0, 8'd0, 8'd9);
      if (tick) found = 1;
    end
    chk("pause_tick_found", int'(found), 1);
    chk("pause_tick_delay", cyc - start_cyc, 14);

    // Restart mid-RUN at count 7 with limit 2: period becomes 3, old limit ignored.
    drive(1, 0, 0, 1, 8'd0, 8'd15, 1'b1);
    for (int i = 0; i < 7; i++) idle_cycle(1'b0, 8'd0, 8'd15);
    chk("restart_pre_count", int'(count), 7);
    drive(1, 0, 0, 1, 8'd0, 8'd2, 1'b1);
    chk("restart_count", int'(count), 0);
    ticks = 0;
    for (int i = 0; i < 9; i++) begin
      idle_cycle(1'b0, 8'd0, 8'd15);
      if (tick) ticks++;
    end
    chk("restart_ticks", ticks, 3);

    // Random operation against the model, with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] lm;
      lm = ($urandom_range(0, 15) == 0) ? 8'(255) : 8'($urandom_range(0, 12));
      drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 3)), lm, 1'b1);
      if ($urandom_range(0, 399) == 0) mid_cycle_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
- Programmable timer controller that sequences the team's free-running up-counter datapath: start/stop/pause, prescaled stepping, terminal-count detection.
- Supports one-shot and periodic operation.
- Produces a one-cycle tick at each terminal count, for use as a periodic enable or timeout by downstream blocks.
- Sits between control software/FSM logic and the counter, replacing unconditional free-run with sequenced operation.

Parameters:
- WIDTH, 8, counter width in bits
- PRE_WIDTH, 8, prescaler width in bits

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse/level: load configuration and (re)start counting
- stop  in  1  abort to IDLE
- pause  in  1  level: freeze counting while high in RUN
- mode  in  1  0 = one-shot, 1 = periodic; sampled on start
- prescale  in  PRE_WIDTH  counter steps every prescale+1 cycles; sampled on start
- limit  in  WIDTH  terminal count value; sampled on start
- count  out  WIDTH  current counter value
- tick  out  1  one-cycle pulse on terminal event
- busy  out  1  high in RUN or PAUSE
- done  out  1  high in DONE (one-shot completed)

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset (async): state IDLE; count, prescaler, shadow regs = 0; tick = busy = done = 0.
- States: IDLE, RUN, PAUSE, DONE. All outputs registered.
- Priority when asserted in the same cycle: stop > start > pause.
- stop (any state): next state IDLE; count holds last value; prescaler cleared; tick = 0; done = 0.
- start (any state, stop low):
  - Latch mode/prescale/limit into shadow regs; count = 0; prescaler = 0; done = 0; next state RUN.
  - Restart from RUN/PAUSE is legal and discards progress.
- RUN:
  - Each cycle with pause low: if prescaler == pre_q, a step occurs and prescaler clears to 0; otherwise prescaler increments.
  - On a step with count != lim_q: count += 1.
  - On a step with count == lim_q (terminal): tick = 1 next cycle.
    - Periodic: count = 0, stay RUN.
    - One-shot: count holds lim_q, next state DONE, done = 1.
  - pause high: next state PAUSE; no step taken that cycle.
- PAUSE: count and prescaler frozen; tick = 0. pause low returns to RUN, resuming with the held prescaler phase.
- DONE: count holds lim_q; done stays high until start or stop.
- Timing:
  - First step occurs pre_q+1 cycles after RUN entry.
  - Terminal period = (lim_q+1)*(pre_q+1) cycles.
  - limit = 0 gives a tick every pre_q+1 cycles.
  - prescale = 0 gives a step every cycle.
- Width rules: count never exceeds lim_q, so no wrap beyond 2^WIDTH-1. limit = all-ones is legal, with period 2^WIDTH*(pre_q+1).
- Live inputs: changes to mode/prescale/limit while busy have no effect until the next start.
- Reset mid-operation: immediate return to reset values regardless of state.

Decomposition:
- Package timer_pkg: state encoding constants (IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3) and mode constants (MODE_ONESHOT = 0, MODE_PERIODIC = 1).
- Sub-module timer_counter holds the counter datapath: WIDTH-bit register with clear, enable and async reset.
- The FSM, prescaler and terminal compare stay in timer_sequencer.

Test Plan:
- Reset: assert reset mid-RUN with count = 5 -> count = 0, busy = 0, done = 0, tick = 0 immediately.
- One-shot: start, mode = 0, prescale = 0, limit = 3 -> count 0,1,2,3; single tick; done = 1, busy = 0; count holds 3.
- Periodic prescaled: mode = 1, prescale = 2, limit = 1 -> tick every 6 cycles; count toggles 0/1 every 3 cycles; busy stays 1 for 30+ cycles.
- Pause: periodic, prescale = 0, limit = 9; pause high for 4 cycles at count = 4 -> count stays 4 throughout; resumes at 5; next tick delayed by exactly 4 cycles.
- Priority: start and stop asserted together during RUN -> IDLE, busy = 0. Then start alone with limit = 0, prescale = 0 -> tick every cycle after RUN entry.
- Restart: start again mid-RUN at count = 7 with new limit = 2 -> count returns to 0; new period = 3 cycles; old limit ignored.
